// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result handshake between the execute stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 64,
    parameter int DEST_WIDTH = 5
);
    logic in_valid;
    logic in_ready;
    logic [2:0] in_op;
    logic in_word;
    logic [XLEN-1:0] in_operand_a;
    logic [XLEN-1:0] in_operand_b;
    logic [DEST_WIDTH-1:0] in_dest_register;
    logic in_flush;
    logic in_stall;
    logic out_valid;
    logic out_ready;
    logic [XLEN-1:0] out_result;
    logic [DEST_WIDTH-1:0] out_dest_register;
    logic busy;

    modport master (
        output in_valid, in_op, in_word, in_operand_a, in_operand_b, in_dest_register,
        output in_flush, in_stall, out_ready,
        input in_ready, out_valid, out_result, out_dest_register, busy
    );

    modport slave (
        input in_valid, in_op, in_word, in_operand_a, in_operand_b, in_dest_register,
        input in_flush, in_stall, out_ready,
        output in_ready, out_valid, out_result, out_dest_register, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide; shift-add multiply, restoring divide,
// single-cycle fast path for divide-by-zero, signed overflow and illegal W multiply-high.
module muldiv_unit #(
    parameter int XLEN = 64,
    parameter int MUL_STEP = 4,
    parameter int DEST_WIDTH = 5
) (
    input logic clk,
    input logic reset,
    muldiv_unit_if.slave io
);
    localparam int CW = $clog2(XLEN + 1);
    typedef enum logic [2:0] {IDLE, MUL, DIV, FIXUP, FAST, DONE} stateT;
    stateT state;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0] opReg;
    logic [CW-1:0] cnt;
    logic [2:0] op;
    logic isWord;
    logic negRes;
    function automatic logic [XLEN-1:0] sx32(input logic [31:0] x);
        return XLEN'($signed(x));
    endfunction
    logic signedA, signedB, signA, signB, divZero, overflow, illegal, fast;
    logic [XLEN-1:0] aExt, bExt, aMag, bMag, dividend, minNeg, fastRes;
    logic [CW-1:0] steps;
    always_comb begin
        signedA = io.in_op == 3'd1 || io.in_op == 3'd2 || (io.in_op[2] && !io.in_op[0]);
        signedB = io.in_op == 3'd1 || (io.in_op[2] && !io.in_op[0]);
        aExt = io.in_word ? (signedA ? sx32(io.in_operand_a[31:0]) : XLEN'(io.in_operand_a[31:0])) : io.in_operand_a;
        bExt = io.in_word ? (signedB ? sx32(io.in_operand_b[31:0]) : XLEN'(io.in_operand_b[31:0])) : io.in_operand_b;
        signA = signedA && aExt[XLEN-1];
        signB = signedB && bExt[XLEN-1];
        aMag = signA ? -aExt : aExt;
        bMag = signB ? -bExt : bExt;
        dividend = io.in_word ? sx32(io.in_operand_a[31:0]) : io.in_operand_a;
        minNeg = io.in_word ? ~XLEN'(32'h7fff_ffff) : {1'b1, {(XLEN-1){1'b0}}};
        illegal = io.in_word && !io.in_op[2] && io.in_op[1:0] != 2'b00;
        divZero = io.in_op[2] && bExt == '0;
        overflow = io.in_op[2] && !io.in_op[0] && aExt == minNeg && bExt == '1;
        fast = illegal || divZero || overflow;
        fastRes = illegal ? '0 : divZero ? (io.in_op[1] ? dividend : '1) : (io.in_op[1] ? '0 : dividend);
        steps = CW'((io.in_word ? 32 : XLEN) / (io.in_op[2] ? 1 : MUL_STEP));
    end
    logic [XLEN+MUL_STEP-1:0] mulHi;
    logic [XLEN:0] divShift;
    logic divGe;
    logic [XLEN-1:0] divDiff, divPick, mulPick, fixRes;
    logic [2*XLEN-1:0] prod;
    always_comb begin
        mulHi = (XLEN+MUL_STEP)'(acc[2*XLEN-1:XLEN]) + (XLEN+MUL_STEP)'(opReg) * (XLEN+MUL_STEP)'(acc[MUL_STEP-1:0]);
        divShift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        divGe = divShift >= {1'b0, opReg};
        divDiff = XLEN'(divShift - {1'b0, opReg});
        // W multiplies stop after 32 bits, leaving the product XLEN-32 bits higher in acc
        prod = isWord ? acc >> (XLEN - 32) : acc;
        prod = negRes ? -prod : prod;
        mulPick = op[1:0] == 2'b00 ? (isWord ? sx32(prod[31:0]) : prod[XLEN-1:0]) : prod[2*XLEN-1:XLEN];
        divPick = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        divPick = negRes ? -divPick : divPick;
        fixRes = op[2] ? (isWord ? sx32(divPick[31:0]) : divPick) : mulPick;
    end
    assign io.in_ready = state == IDLE;
    assign io.busy = state != IDLE;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc <= '0;
            opReg <= '0;
            cnt <= '0;
            op <= '0;
            isWord <= 1'b0;
            negRes <= 1'b0;
            io.out_valid <= 1'b0;
            io.out_result <= '0;
            io.out_dest_register <= '0;
        end else if (io.in_flush) begin
            state <= IDLE;
            io.out_valid <= 1'b0;
        end else if (!io.in_stall) begin
            case (state)
                IDLE: if (io.in_valid) begin
                    op <= io.in_op;
                    isWord <= io.in_word;
                    io.out_dest_register <= io.in_dest_register;
                    // remainder takes the dividend sign; everything else the xor of both
                    negRes <= signA ^ (signB && !(io.in_op[2] && io.in_op[1]));
                    opReg <= io.in_op[2] ? bMag : aMag;
                    acc <= {{XLEN{1'b0}}, fast ? fastRes : io.in_op[2] ? aMag << (io.in_word ? XLEN - 32 : 0) : bMag};
                    cnt <= steps;
                    state <= fast ? FAST : io.in_op[2] ? DIV : MUL;
                end
                MUL: begin
                    acc <= {mulHi, acc[XLEN-1:MUL_STEP]};
                    cnt <= cnt - CW'(1);
                    state <= cnt == CW'(1) ? FIXUP : MUL;
                end
                DIV: begin
                    acc <= {divGe ? divDiff : divShift[XLEN-1:0], acc[XLEN-2:0], divGe};
                    cnt <= cnt - CW'(1);
                    state <= cnt == CW'(1) ? FIXUP : DIV;
                end
                FIXUP: begin
                    io.out_result <= fixRes;
                    io.out_valid <= 1'b1;
                    state <= DONE;
                end
                FAST: begin
                    io.out_result <= acc[XLEN-1:0];
                    io.out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (io.out_ready) begin
                    io.out_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit (XLEN=64, MUL_STEP=4) with hand-computed results
// and latencies counted in edges from the accepting edge to out_valid.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checkCount = 0;
    int passCount = 0;
    logic sawValid;
    muldiv_unit_if #(.XLEN(64), .DEST_WIDTH(5)) io ();
    muldiv_unit #(.XLEN(64), .MUL_STEP(4), .DEST_WIDTH(5)) dut (.clk(clk), .reset(reset), .io(io));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checkCount++;
        assert (got === want) passCount++;
        else $error("FAIL %s: got %h expected %h", tag, got, want);
    endtask

    task automatic drive(input logic [2:0] op, input logic word, input logic [63:0] a, input logic [63:0] b, input logic [4:0] dest);
        io.in_valid = 1'b1;
        io.in_op = op;
        io.in_word = word;
        io.in_operand_a = a;
        io.in_operand_b = b;
        io.in_dest_register = dest;
        @(posedge clk);
        #1;
        io.in_valid = 1'b0;
    endtask

    task automatic runOp(input string tag, input logic [2:0] op, input logic word, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] dest, input logic [63:0] want,
                         input int lat, input int stallAt, input int hold);
        int n;
        logic [63:0] held;
        drive(op, word, a, b, dest);
        n = 1;
        while (io.out_valid !== 1'b1 && n < 300) begin
            if (stallAt != 0 && n == stallAt) io.in_stall = 1'b1;
            if (stallAt != 0 && n == stallAt + 5) io.in_stall = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        io.in_stall = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, io.out_result, want);
        check({tag, " dest"}, 64'(io.out_dest_register), 64'(dest));
        if (hold > 0) begin
            held = io.out_result;
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            check({tag, " held result"}, io.out_result, held);
            check({tag, " held valid"}, 64'(io.out_valid), 64'd1);
            check({tag, " held in_ready"}, 64'(io.in_ready), 64'd0);
        end
        io.out_ready = 1'b1;
        @(posedge clk);
        #1;
        io.out_ready = 1'b0;
        check({tag, " in_ready after take"}, 64'(io.in_ready), 64'd1);
    endtask

    initial begin
        io.in_valid = 1'b0;
        io.in_op = 3'd0;
        io.in_word = 1'b0;
        io.in_operand_a = '0;
        io.in_operand_b = '0;
        io.in_dest_register = '0;
        io.in_flush = 1'b0;
        io.in_stall = 1'b0;
        io.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 64'(io.out_valid), 64'd0);
        check("reset out_result", io.out_result, 64'd0);
        check("reset dest", 64'(io.out_dest_register), 64'd0);
        check("reset busy", 64'(io.busy), 64'd0);
        reset = 1'b0;
        #1;
        check("reset in_ready", 64'(io.in_ready), 64'd1);

        runOp("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd17, 64'hFFFF_FFFF_FFFF_FFEB, 18, 0, 0);
        runOp("mulh", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 18, 0, 0);
        runOp("mulhu", 3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 5'd2, 64'd1, 18, 0, 0);
        runOp("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 18, 0, 0);

        runOp("divu by 0", 3'd5, 1'b0, 64'd100, 64'd0, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0, 0);
        runOp("rem by 0", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd5, 64'hFFFF_FFFF_FFFF_FFFB, 2, 0, 0);
        runOp("div ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 64'h8000_0000_0000_0000, 2, 0, 0);
        runOp("rem ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 64'd0, 2, 0, 0);

        runOp("divw ovf", 3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd8, 64'hFFFF_FFFF_8000_0000, 2, 0, 0);
        runOp("remw", 3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 34, 0, 0);
        runOp("mulw", 3'd0, 1'b1, 64'h0000_0001_0000_0002, 64'd3, 5'd10, 64'd6, 10, 0, 0);
        runOp("mulhw illegal", 3'd1, 1'b1, 64'd5, 64'd7, 5'd11, 64'd0, 2, 0, 0);

        drive(3'd4, 1'b0, 64'd1000, 64'd7, 5'd12);
        repeat (9) @(posedge clk);
        #1;
        io.in_flush = 1'b1;
        io.in_valid = 1'b1;
        @(posedge clk);
        #1;
        io.in_flush = 1'b0;
        io.in_valid = 1'b0;
        check("flush in_ready", 64'(io.in_ready), 64'd1);
        check("flush busy", 64'(io.busy), 64'd0);
        sawValid = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (io.out_valid) sawValid = 1'b1;
        end
        check("flush no out_valid", 64'(sawValid), 64'd0);
        runOp("divu after flush", 3'd5, 1'b0, 64'd9, 64'd2, 5'd13, 64'd4, 66, 0, 0);

        runOp("mul stalled", 3'd0, 1'b0, 64'd12345, 64'd678, 5'd14, 64'd8369910, 23, 5, 0);
        runOp("div hold", 3'd4, 1'b0, 64'd100, 64'd7, 5'd21, 64'd14, 66, 0, 3);
        runOp("remu", 3'd7, 1'b0, 64'd100, 64'd7, 5'd22, 64'd2, 66, 0, 0);

        drive(3'd4, 1'b0, 64'd1000, 64'd7, 5'd9);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid reset out_valid", 64'(io.out_valid), 64'd0);
        check("mid reset out_result", io.out_result, 64'd0);
        check("mid reset dest", 64'(io.out_dest_register), 64'd0);
        check("mid reset busy", 64'(io.busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid reset in_ready", 64'(io.in_ready), 64'd1);
        runOp("div neg", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd15, 64'hFFFF_FFFF_FFFF_FFFA, 66, 0, 0);
        runOp("rem neg", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd16, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative, parametrised RV64M multiply/divide unit. It sits beside the single-cycle execute ALU and takes all M-extension ops (including W variants) off the ALU's critical path.
- Operands are accepted with a valid/ready handshake once forwarding has resolved them.
- The result is held with its destination register until the downstream stage takes it.
- The unit honours the pipeline's cache-stall and flush signals.

Parameters:
XLEN, 64, datapath width (32 or 64).
MUL_STEP, 4, multiplier bits retired per iteration cycle; must divide 32.
DEST_WIDTH, 5, destination-register tag width.

Ports:
clk  input  1  clock.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  request present.
in_ready  output  1  unit can accept; high only in IDLE.
in_op  input  3  funct3 order: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
in_word  input  1  W variant: operate on bits [31:0] and sign-extend the 32-bit result.
in_operand_a  input  XLEN  rs1 value, already forwarded.
in_operand_b  input  XLEN  rs2 value, already forwarded.
in_dest_register  input  DEST_WIDTH  rd tag.
in_flush  input  1  abort the op in flight (jump or ecall flush).
in_stall  input  1  OR of the dcache and icache stalls; freezes the unit.
out_valid  output  1  result available.
out_ready  input  1  consumer takes the result.
out_result  output  XLEN  result.
out_dest_register  output  DEST_WIDTH  rd tag of the result.
busy  output  1  state is not IDLE.

Behaviour:
- Reset values: state=IDLE; out_valid=0; out_result=0; out_dest_register=0; busy=0; in_ready=1 after reset deasserts.
- Priority, highest first: reset > in_flush > in_stall > normal operation.
- Flush: in_flush in any state goes to IDLE on the next edge. out_valid drops, the result is discarded, and a same-cycle in_valid is not accepted.
- Stall: in_stall freezes state, counter, accumulators and outputs. No accept and no out_ready consumption happen during a stall.
- Accept happens on an edge where in_valid && in_ready && !in_stall && !in_flush. At accept the unit:
  - latches op, word, dest;
  - computes operand magnitudes (signed ops only; mulhsu treats only a as signed) and records the result sign;
  - uses W = 32 if in_word else XLEN, and sign-extends 32-bit operands before taking magnitudes.
- States:
  - IDLE: on accept, go to FAST if the fast path applies, else MUL (ops 0xx) or DIV (ops 1xx).
  - MUL: shift-add of MUL_STEP bits per cycle into a 2*XLEN accumulator; runs N = W/MUL_STEP cycles, then FIXUP.
  - DIV: restoring radix-2, one quotient bit per cycle; runs N = W cycles, then FIXUP.
  - FIXUP: negate if the sign flag is set (quotient sign = sign a XOR sign b; remainder sign = dividend sign), select the result field, sign-extend for W ops, then DONE.
  - FAST: one cycle, then DONE.
  - DONE: out_valid=1 with out_result and out_dest_register stable. When out_ready && !in_stall, go to IDLE; in_ready rises the following cycle.
- Latency (edges from accept to out_valid high): N+2 normally; 2 on the fast path.
- Result field selection:
  - mul: product[XLEN-1:0].
  - mulh, mulhsu, mulhu: product[2*XLEN-1:XLEN].
  - mulw: product[31:0], sign-extended.
- Fast path:
  - Divisor = 0: div/divu give all ones (W-wide, sign-extended); rem/remu give the dividend.
  - Signed overflow (a = most-negative W-bit value, b = -1): div gives a; rem gives 0.
- Illegal combination (in_word with mulh, mulhsu or mulhu): result 0 via the fast path.
- No back-to-back overlap: one op in flight at a time.
- Reset asserted mid-operation returns to IDLE asynchronously with all outputs at their reset values.

Test Plan:
1. mul a=7, b=0xFFFF_FFFF_FFFF_FFFD (XLEN=64, MUL_STEP=4) -> out_result 0xFFFF_FFFF_FFFF_FFEB, out_valid exactly 18 edges after accept, dest tag preserved.
2. mulh a=0x8000_0000_0000_0000, b=2 -> 0xFFFF_FFFF_FFFF_FFFF; mulhu with the same operands -> 0x1; mulhsu a=-1, b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFF.
3. Fast path:
   - divu a=100, b=0 -> 0xFFFF_FFFF_FFFF_FFFF at latency 2.
   - rem a=-5, b=0 -> 0xFFFF_FFFF_FFFF_FFFB.
   - div a=0x8000_0000_0000_0000, b=-1 -> 0x8000_0000_0000_0000.
   - rem with the same operands -> 0.
4. W ops:
   - divw a=0x0000_0001_8000_0000, b=0xFFFF_FFFF -> 0xFFFF_FFFF_8000_0000 (fast path).
   - remw a=-7, b=2 -> 0xFFFF_FFFF_FFFF_FFFF at latency 34.
   - mulw a=0x1_0000_0002, b=3 -> 6.
5. Control:
   - in_flush 10 cycles into div -> no out_valid; in_ready high on the next cycle; the next divu 9/2 returns 4.
   - 5-cycle in_stall mid-mul -> latency 18+5 with the correct result.
   - out_ready low for 3 cycles in DONE -> result held stable, in_ready stays low.
6. reset pulsed mid-DIV -> all outputs at reset values immediately; a subsequent div a=-20, b=3 returns -6 and rem returns -2.
